reg_alu_engine: RTL
===================

REG_ALU_ENGINE -- requirements
Module: reg_alu_engine

Interface
REQ-001 Parameter: WIDTH, 16, datapath and register width in bits; legal values are powers of two from 8 to 64.
REQ-002 Parameter: NREG, 8, number of registers; legal values are powers of two of at least 4; AW = log2(NREG).
REQ-003 Port: clk  input  1  single clock; all state changes on the rising edge.
REQ-004 Port: rst  input  1  reset; asynchronous and active-high.
REQ-005 Port: instr_valid  input  1  instruction fields are valid.
REQ-006 Port: instr_ready  output  1  engine accepts an instruction this cycle.
REQ-007 Port: opcode  input  4  operation select.
REQ-008 Port: src1, src2, dest  input  AW each  register addresses.
REQ-009 Port: imm  input  WIDTH  immediate operand for LOADI.
REQ-010 Port: done  output  1  one-cycle completion pulse.
REQ-011 Port: result  output  WIDTH  last value computed by a completed instruction.
REQ-012 Port: zero, carry, err  output  1 each  status flags.
REQ-013 Port: rd_addr  input  AW  observation read address.
REQ-014 Port: rd_data  output  WIDTH  combinational read of register rd_addr.

Function
REQ-015 Register file: NREG x WIDTH; R0 SHALL always read 0, and writes to R0 SHALL be discarded.
REQ-016 Accept: an instruction is accepted on a rising edge where instr_valid=1 and instr_ready=1; instr_ready=1 only in IDLE.
REQ-017 FSM states: IDLE, MUL, DONE.
- IDLE -> MUL on accepting opcode 11.
- IDLE -> DONE on accepting any other opcode.
- MUL -> DONE after WIDTH iterations.
- DONE -> IDLE unconditionally.
REQ-018 Opcodes (a=R[src1], b=R[src2]):
- 0 NOP
- 1 ADD a+b
- 2 SUB a-b
- 3 AND
- 4 OR
- 5 XOR
- 6 NOT a
- 7 SHL a<<b[log2(WIDTH)-1:0]
- 8 SHR logical, same shift amount
- 9 LOADI imm
- 10 MOV a
- 11 MUL low WIDTH bits of a*b
- 12-15 illegal
REQ-019 Non-MUL opcodes: the result SHALL be written to dest on the accepting edge; done=1 in the following cycle (latency 1).
REQ-020 MUL: operands SHALL be latched on accept, then shift-add for WIDTH cycles; the dest write occurs on the WIDTH-th edge after accept; done=1 in the following cycle (latency WIDTH+1).
REQ-021 Hazards: src1/src2 reads use register contents before the write of the same instruction; dest == src is legal.
REQ-022 Pulse: done SHALL be high for exactly one cycle per accepted instruction, including NOP and illegal opcodes.
REQ-023 Flags:
- zero and result update on every writing opcode (1-11), even when dest=R0.
- carry = ADD carry-out or SUB borrow; carry = 0 for the other writing opcodes.
- NOP leaves result, zero and carry unchanged.
REQ-024 err: set to 1 on an illegal opcode, with no register, result, zero or carry change; cleared by the next accepted legal opcode.
REQ-025 Busy behaviour: instr_valid while in MUL or DONE SHALL be ignored, with no side effects; inputs are only sampled on accept.
REQ-026 Arithmetic: all arithmetic is modulo 2^WIDTH; a shift amount of 0 passes a unchanged.

Reset
REQ-027 While rst=1, immediately and independent of clk:
- all registers = 0, state = IDLE
- instr_ready = 1
- done, result, zero, carry, err = 0
REQ-028 Reset during MUL or DONE SHALL abort the operation: no write occurs and no done pulse is produced.
REQ-029 The first accept is possible on the first rising edge after rst falls.

Verification (WIDTH=16, NREG=8)
REQ-030 Reset: assert rst mid-cycle -> all rd_data = 0, instr_ready = 1, done = 0 without any clock edge.
REQ-031 ALU: LOADI R1=0x0005, LOADI R2=0x0003, then ADD R3=R1+R2 -> R3 = 0x0008, zero = 0, carry = 0, done one cycle after each accept.
REQ-032 Borrow and zero: SUB R4=R2-R1 -> 0xFFFE, carry = 1; then XOR R5=R1^R1 -> 0x0000, zero = 1, carry = 0.
REQ-033 MUL: MUL R6=R1*R2 -> 0x000F.
- done exactly 17 cycles after accept.
- instr_ready = 0 for 17 cycles.
- an instruction held valid during MUL is not taken.
REQ-034 Write-discard and error cases:
- LOADI R0=0x1234 -> rd_data(R0) = 0, result = 0x1234.
- opcode 13 -> err = 1, no register change, done pulses once.
- next legal opcode -> err = 0.
REQ-035 Reset mid-MUL: assert rst 5 cycles into MUL -> no done pulse, all registers = 0; a new LOADI after release completes normally.

Source files
------------

// File: rtl/reg_alu_engine.sv
// Register-file ALU engine: single-issue instructions, one-cycle ALU ops and a
// WIDTH-cycle shift-add multiplier, with a combinational observation read port.
`timescale 1ns/1ps
module reg_alu_engine #(
   parameter int WIDTH = 16,
   parameter int NREG  = 8,
   localparam int AW   = $clog2(NREG),
   localparam int SW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             instr_valid,
   output logic             instr_ready,
   input  logic [3:0]       opcode,
   input  logic [AW-1:0]    src1,
   input  logic [AW-1:0]    src2,
   input  logic [AW-1:0]    dest,
   input  logic [WIDTH-1:0] imm,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             carry,
   output logic             err,
   input  logic [AW-1:0]    rd_addr,
   output logic [WIDTH-1:0] rd_data
);

   localparam logic [3:0] OP_NOP  = 4'd0;
   localparam logic [3:0] OP_ADD  = 4'd1;
   localparam logic [3:0] OP_SUB  = 4'd2;
   localparam logic [3:0] OP_AND  = 4'd3;
   localparam logic [3:0] OP_OR   = 4'd4;
   localparam logic [3:0] OP_XOR  = 4'd5;
   localparam logic [3:0] OP_NOT  = 4'd6;
   localparam logic [3:0] OP_SHL  = 4'd7;
   localparam logic [3:0] OP_SHR  = 4'd8;
   localparam logic [3:0] OP_LDI  = 4'd9;
   localparam logic [3:0] OP_MOV  = 4'd10;
   localparam logic [3:0] OP_MUL  = 4'd11;

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_e;

   state_e state_q, state_d;

   logic [WIDTH-1:0] regs_q [NREG];
   logic [WIDTH-1:0] op_a, op_b;
   logic [WIDTH:0]   add_ext, sub_ext;
   logic [WIDTH-1:0] alu_res;
   logic             alu_carry, alu_wr, illegal;
   logic             accept;

   logic [WIDTH-1:0] acc_q, mcand_q, mplier_q, mul_sum;
   logic [SW-1:0]    cnt_q;
   logic [AW-1:0]    dest_q;
   logic             mul_last;

   logic             wr_en;
   logic [AW-1:0]    wr_addr;
   logic [WIDTH-1:0] wr_data;

   logic [WIDTH-1:0] result_q;
   logic             zero_q, carry_q, err_q;

   // ---------------- FSM ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:  if (accept) state_d = (opcode == OP_MUL) ? S_MUL : S_DONE;
         S_MUL:   if (mul_last) state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // done decodes straight from state so an async reset kills the pulse at once
   always_comb begin
      instr_ready = (state_q == S_IDLE);
      done        = (state_q == S_DONE);
   end

   assign accept = instr_valid & instr_ready;

   // ---------------- ALU ----------------
   assign op_a    = regs_q[src1];
   assign op_b    = regs_q[src2];
   assign add_ext = {1'b0, op_a} + {1'b0, op_b};
   assign sub_ext = {1'b0, op_a} - {1'b0, op_b};

   always_comb begin
      alu_res   = '0;
      alu_carry = 1'b0;
      alu_wr    = 1'b1;
      illegal   = 1'b0;
      unique case (opcode)
         OP_NOP:  alu_wr = 1'b0;
         OP_ADD:  {alu_carry, alu_res} = add_ext;
         OP_SUB:  {alu_carry, alu_res} = sub_ext;
         OP_AND:  alu_res = op_a & op_b;
         OP_OR:   alu_res = op_a | op_b;
         OP_XOR:  alu_res = op_a ^ op_b;
         OP_NOT:  alu_res = ~op_a;
         OP_SHL:  alu_res = op_a << op_b[SW-1:0];
         OP_SHR:  alu_res = op_a >> op_b[SW-1:0];
         OP_LDI:  alu_res = imm;
         OP_MOV:  alu_res = op_a;
         OP_MUL:  alu_wr  = 1'b0;
         default: begin
            alu_wr  = 1'b0;
            illegal = 1'b1;
         end
      endcase
   end

   // ---------------- shift-add multiplier ----------------
   assign mul_sum  = acc_q + (mplier_q[0] ? mcand_q : '0);
   assign mul_last = (state_q == S_MUL) && (cnt_q == SW'(WIDTH - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         cnt_q    <= '0;
         dest_q   <= '0;
      end else if (accept && opcode == OP_MUL) begin
         acc_q    <= '0;
         mcand_q  <= op_a;
         mplier_q <= op_b;
         cnt_q    <= '0;
         dest_q   <= dest;
      end else if (state_q == S_MUL) begin
         acc_q    <= mul_sum;
         mcand_q  <= mcand_q << 1;
         mplier_q <= mplier_q >> 1;
         cnt_q    <= cnt_q + SW'(1);
      end
   end

   // ---------------- register file ----------------
   always_comb begin
      wr_en   = 1'b0;
      wr_addr = dest;
      wr_data = alu_res;
      if (accept && alu_wr) begin
         wr_en = 1'b1;
      end else if (mul_last) begin
         wr_en   = 1'b1;
         wr_addr = dest_q;
         wr_data = mul_sum;
      end
   end

   // R0 is never written, so it holds its reset value of zero
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
      end else if (wr_en && wr_addr != '0) begin
         regs_q[wr_addr] <= wr_data;
      end
   end

   assign rd_data = regs_q[rd_addr];

   // ---------------- result / flags ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         result_q <= '0;
         zero_q   <= 1'b0;
         carry_q  <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         if (accept) begin
            err_q <= illegal;
            if (alu_wr) begin
               result_q <= alu_res;
               zero_q   <= (alu_res == '0);
               carry_q  <= alu_carry;
            end
         end
         if (mul_last) begin
            result_q <= mul_sum;
            zero_q   <= (mul_sum == '0);
            carry_q  <= 1'b0;
         end
      end
   end

   assign result = result_q;
   assign zero   = zero_q;
   assign carry  = carry_q;
   assign err    = err_q;

endmodule
